param_router: RTL and testbench
===============================

PARAM_ROUTER -- requirements
Module: param_router

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3: ports 0..NUM_PORTS-1; port 0 is local (CPU), the rest are neighbour links.
REQ-002 SHALL have parameter FLIT_W, default 64: flit width; bit FLIT_W-1 = head, bit FLIT_W-2 = tail, bits NODE_W-1:0 = destination id (head flits only).
REQ-003 SHALL have parameter NODE_W, default 4: node id width; routing table has 2^NODE_W entries.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: per-input FIFO depth, power of two, >=2.
REQ-005 SHALL have port nocclk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  one clock; reset is synchronous and active-high.
REQ-007 SHALL have port in_flit  in  NUM_PORTS*FLIT_W  input flits, port p at slice p.
REQ-008 SHALL have ports in_valid (in) and in_ready (out), each NUM_PORTS bits: per-input handshake.
REQ-009 SHALL have port out_flit  out  NUM_PORTS*FLIT_W  output flits, same slicing.
REQ-010 SHALL have ports out_valid (out) and out_ready (in), each NUM_PORTS bits: per-output handshake.
REQ-011 SHALL have port self_id  in  NODE_W  this node's id, quasi-static.
REQ-012 SHALL have ports tbl_we (in, 1), tbl_addr (in, NODE_W) and tbl_data (in, $clog2(NUM_PORTS)): routing-table write.
REQ-013 SHALL have port err_count  out  8  saturating count of discarded flits.

Function
REQ-014 Transfer occurs only on a cycle with valid && ready; valid, once high, SHALL stay high with a stable flit until the transfer (both directions).
REQ-015 in_ready[p] SHALL be high when FIFO p is not full, registered-free (combinational from occupancy); push and pop in the same cycle on a full FIFO SHALL NOT be allowed (ready stays low when full).
REQ-016 Route of a head flit: destination == self_id -> port 0; else table[destination].
REQ-017 A table entry >= NUM_PORTS SHALL cause the whole packet (head through tail) to be popped and discarded at one flit per cycle, each discarded flit incrementing err_count.
REQ-018 A table write SHALL take effect the cycle after tbl_we; a lookup in the same cycle uses the old value.
REQ-019 Each output SHALL have an independent round-robin arbiter over inputs whose FIFO-head head flit routes to it; search starts at rr_ptr.
REQ-020 Wormhole: when a granted head flit transfers, output o SHALL lock to input i until i's tail flit transfers on o; no other input is granted o meanwhile.
REQ-021 A granted head with out_ready low SHALL keep its grant; no re-arbitration while out_valid is high.
REQ-022 Route SHALL be captured at head transfer; later table writes do not affect an in-flight packet.
REQ-023 On tail transfer, rr_ptr[o] SHALL become (i+1) mod NUM_PORTS and the lock is released the same cycle; re-arbitration occurs the next cycle.
REQ-024 A flit with head and tail both set SHALL be a single-flit packet: lock and release in one transfer.
REQ-025 A non-head flit at a FIFO head of an input holding no lock SHALL be discarded (1/cycle) with err_count increment.
REQ-026 err_count SHALL saturate at 255; multiple simultaneous discards increment by the number discarded, saturating.
REQ-027 Routing to the arriving port (U-turn) SHALL be permitted.
REQ-028 Minimum latency: flit accepted at edge t SHALL be presentable on out_flit in the cycle after t; full throughput of one flit/cycle per output with ready held high.
REQ-029 Different outputs SHALL transfer in parallel in the same cycle.

Reset
REQ-030 When rst is high at an edge: all FIFOs empty, all locks cleared, rr_ptr = 0, table entries = 0, err_count = 0.
REQ-031 During and one cycle after reset: in_ready = 0 while rst high, out_valid = 0, out_flit = 0.
REQ-032 Reset mid-packet SHALL drop all partial packets; no flit accepted before reset appears after.

Verification
REQ-033 Single-flit head+tail, dest = self_id = 3, into port 1 -> appears on port 0 next cycle, err_count 0.
REQ-034 table[5] = 2; ports 0 and 1 each send a 3-flit packet to 5 in the same cycle -> port 2 carries 3 flits of port 0, then 3 of port 1, never interleaved.
REQ-035 out_ready[2] held low 4 cycles mid-packet -> out_flit stable, in_ready[src] falls when its FIFO has 4 entries, no flit lost.
REQ-036 table[7] = 3 (NUM_PORTS = 3), 4-flit packet to 7 -> all dropped, err_count = 4; orphan body flit into idle port -> err_count = 5.
REQ-037 tbl_we rewrites table[5] the cycle after a head to 5 transfers -> remaining flits follow the original port; next packet uses the new port.
REQ-038 rst pulsed mid-packet -> all out_valid = 0, err_count = 0, table reads 0, subsequent packet routes correctly.

Source files
------------

// File: rtl/param_router.sv
// param_router: wormhole NoC router with per-input FIFOs, table routing and per-output round-robin arbitration
module param_router #(
  parameter int NUM_PORTS  = 3,
  parameter int FLIT_W     = 64,
  parameter int NODE_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          nocclk,
  input  logic                          rst,
  input  logic [NUM_PORTS*FLIT_W-1:0]   in_flit,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS*FLIT_W-1:0]   out_flit,
  output logic [NUM_PORTS-1:0]          out_valid,
  input  logic [NUM_PORTS-1:0]          out_ready,
  input  logic [NODE_W-1:0]             self_id,
  input  logic                          tbl_we,
  input  logic [NODE_W-1:0]             tbl_addr,
  input  logic [$clog2(NUM_PORTS)-1:0]  tbl_data,
  output logic [7:0]                    err_count
);
  localparam int N  = NUM_PORTS;
  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NUM_PORTS + 1);
  logic [FLIT_W-1:0] mem_q [N][FIFO_DEPTH];
  logic [AW:0]       wp_q [N];
  logic [AW:0]       rp_q [N];
  logic [PW-1:0]     tbl_q [2**NODE_W];
  logic [PW-1:0]     oin_q [N];
  logic [PW-1:0]     rr_q [N];
  logic [PW-1:0]     route [N];
  logic [PW-1:0]     sel [N];
  logic [FLIT_W-1:0] hf [N];
  logic [N-1:0]      req [N];
  logic [N-1:0]      drop_q, olock_q, ne, full, push, pop, hd, tl, bad, ilock, disc, xfer;
  logic [7:0]        err_q, err_d;
  logic [CW-1:0]     cnt;
  logic [8:0]        tot;
  // FIFO status, head-flit decode, routing lookup and discard decisions per input
  always_comb begin
    ilock = '0;
    for (int o = 0; o < N; o++) if (olock_q[o]) ilock[oin_q[o]] = 1'b1;
    for (int i = 0; i < N; i++) begin
      hf[i]       = mem_q[i][rp_q[i][AW-1:0]];
      ne[i]       = wp_q[i] != rp_q[i];
      full[i]     = (wp_q[i][AW] != rp_q[i][AW]) && (wp_q[i][AW-1:0] == rp_q[i][AW-1:0]);
      in_ready[i] = !full[i] && !rst;
      push[i]     = in_valid[i] && in_ready[i];
      hd[i]       = hf[i][FLIT_W-1];
      tl[i]       = hf[i][FLIT_W-2];
      route[i]    = (hf[i][NODE_W-1:0] == self_id) ? '0 : tbl_q[hf[i][NODE_W-1:0]];
      bad[i]      = int'(route[i]) >= N;
      disc[i]     = ne[i] && !rst && (drop_q[i] || (!ilock[i] && (!hd[i] || bad[i])));
    end
  end
  // per-output grant: follow the lock if held, else round-robin from rr_q over routable heads
  always_comb begin
    out_flit = '0;
    pop      = disc;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++)
        req[o][i] = ne[i] && hd[i] && !ilock[i] && !drop_q[i] && !bad[i] && route[i] == PW'(o);
      sel[o]       = oin_q[o];
      out_valid[o] = olock_q[o] && ne[oin_q[o]] && !rst;
      for (int k = N - 1; k >= 0; k--)
        if (!olock_q[o] && req[o][(int'(rr_q[o]) + k) % N]) begin
          sel[o]       = PW'((int'(rr_q[o]) + k) % N);
          out_valid[o] = !rst;
        end
      out_flit[o*FLIT_W +: FLIT_W] = out_valid[o] ? hf[sel[o]] : '0;
      xfer[o] = out_valid[o] && out_ready[o];
      if (xfer[o]) pop[sel[o]] = 1'b1;
    end
  end
  // saturating error counter advances by the number of flits discarded this cycle
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + CW'(disc[i]);
    tot   = {1'b0, err_q} + 9'(cnt);
    err_d = tot[8] ? 8'hff : tot[7:0];
  end
  assign err_count = err_q;
  // FIFO storage needs no reset: pointers alone define occupancy
  always_ff @(posedge nocclk)
    for (int i = 0; i < N; i++) if (push[i]) mem_q[i][wp_q[i][AW-1:0]] <= in_flit[i*FLIT_W +: FLIT_W];
  // pointers, drop mode, output locks, round-robin pointers, routing table and error count
  always_ff @(posedge nocclk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        oin_q[i] <= '0;
        rr_q[i]  <= '0;
      end
      for (int a = 0; a < 2**NODE_W; a++) tbl_q[a] <= '0;
      drop_q  <= '0;
      olock_q <= '0;
      err_q   <= '0;
    end else begin
      if (tbl_we) tbl_q[tbl_addr] <= tbl_data;
      err_q <= err_d;
      for (int i = 0; i < N; i++) begin
        if (push[i]) wp_q[i] <= wp_q[i] + 1'b1;
        if (pop[i]) rp_q[i] <= rp_q[i] + 1'b1;
        if (disc[i]) drop_q[i] <= !tl[i] && (drop_q[i] || (hd[i] && bad[i]));
      end
      for (int o = 0; o < N; o++)
        if (xfer[o] && tl[sel[o]]) begin
          olock_q[o] <= 1'b0;
          rr_q[o]    <= (int'(sel[o]) == N - 1) ? '0 : sel[o] + PW'(1);
        end else if (out_valid[o]) begin
          olock_q[o] <= 1'b1;
          oin_q[o]   <= sel[o];
        end
    end
  end
endmodule

// File: tb/tb_param_router.sv
// tb_param_router: directed checks of routing, wormhole locking, backpressure, discards and reset
module tb_param_router;
  logic         nocclk = 1'b0;
  logic         rst = 1'b1;
  logic [191:0] in_flit = '0;
  logic [2:0]   in_valid = '0;
  logic [2:0]   in_ready;
  logic [191:0] out_flit;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready = 3'b111;
  logic [3:0]   self_id = 4'd3;
  logic         tbl_we = 1'b0;
  logic [3:0]   tbl_addr = '0;
  logic [1:0]   tbl_data = '0;
  logic [7:0]   err_count;
  int           tests = 0;
  int           fails = 0;
  logic [63:0]  lg0[$];
  logic [63:0]  lg1[$];
  logic [63:0]  lg2[$];

  always #5 nocclk = ~nocclk;

  param_router dut (
    .nocclk(nocclk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready), .self_id(self_id),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .err_count(err_count)
  );

  // log every flit that leaves each output
  always @(posedge nocclk) begin
    if (out_valid[0] && out_ready[0]) lg0.push_back(out_flit[63:0]);
    if (out_valid[1] && out_ready[1]) lg1.push_back(out_flit[127:64]);
    if (out_valid[2] && out_ready[2]) lg2.push_back(out_flit[191:128]);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] mk(input int h, input int t, input int d, input int p);
    return {h[0], t[0], 14'b0, p[15:0], 28'b0, d[3:0]};
  endfunction

  function automatic int lsz(input int o);
    return o == 0 ? lg0.size() : o == 1 ? lg1.size() : lg2.size();
  endfunction

  function automatic logic [63:0] lget(input int o, input int k);
    return o == 0 ? lg0[k] : o == 1 ? lg1[k] : lg2[k];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input logic [63:0] f);
    int n = 0;
    in_valid[p] = 1'b1;
    in_flit[p*64 +: 64] = f;
    do begin
      @(negedge nocclk);
      n++;
    end while (!in_ready[p] && n < 100);
    if (n >= 100) chk("push_timeout", 64'(in_ready[p]), 64'd1);
    @(posedge nocclk);
    #1;
    in_valid[p] = 1'b0;
  endtask

  task automatic pkt(input int p, input int d, input int base, input int len);
    for (int k = 0; k < len; k++) push(p, mk(k == 0, k == len - 1, d, base + k));
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] d);
    tbl_we = 1'b1;
    tbl_addr = a;
    tbl_data = d;
    @(posedge nocclk);
    #1;
    tbl_we = 1'b0;
  endtask

  task automatic wait_log(input int o, input int n);
    int c = 0;
    while (lsz(o) < n && c < 200) begin
      @(posedge nocclk);
      #1;
      c++;
    end
    chk("wait_log", 64'(lsz(o) >= n), 64'd1);
  endtask

  initial begin
    int b0, b1, b2;
    repeat (2) @(posedge nocclk);
    @(negedge nocclk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_flit", out_flit[63:0] | out_flit[127:64] | out_flit[191:128], 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    @(posedge nocclk);
    #1;
    rst = 1'b0;
    @(negedge nocclk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd7);
    @(posedge nocclk);
    #1;
    // single-flit packet to self goes to local port the next cycle
    push(1, mk(1, 1, 3, 'hA1));
    @(negedge nocclk);
    chk("local_valid", 64'(out_valid), 64'd1);
    chk("local_flit", out_flit[63:0], mk(1, 1, 3, 'hA1));
    @(posedge nocclk);
    #1;
    chk("local_logged", 64'(lsz(0)), 64'd1);
    chk("local_err", 64'(err_count), 64'd0);
    // two simultaneous 3-flit packets to output 2 are never interleaved
    wr(4'd5, 2'd2);
    fork
      pkt(0, 5, 'h10, 3);
      pkt(1, 5, 'h20, 3);
    join
    wait_log(2, 6);
    for (int k = 0; k < 3; k++) begin
      chk("rr_first", lget(2, k), mk(k == 0, k == 2, 5, 'h10 + k));
      chk("rr_second", lget(2, k + 3), mk(k == 0, k == 2, 5, 'h20 + k));
    end
    // output stall mid-packet: flit held, input fills to full, nothing lost
    fork
      pkt(1, 5, 'h30, 6);
      begin
        int c = 0;
        while (lsz(2) < 7 && c < 100) begin
          @(posedge nocclk);
          #1;
          c++;
        end
        out_ready[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge nocclk);
          chk("stall_valid", 64'(out_valid[2]), 64'd1);
          chk("stall_flit", out_flit[191:128], mk(0, 0, 5, 'h31));
          if (k == 2) chk("stall_ready3", 64'(in_ready[1]), 64'd1);
          if (k == 3) chk("stall_full", 64'(in_ready[1]), 64'd0);
        end
        @(posedge nocclk);
        #1;
        out_ready[2] = 1'b1;
      end
    join
    wait_log(2, 12);
    for (int k = 0; k < 6; k++) chk("stall_data", lget(2, 6 + k), mk(k == 0, k == 5, 5, 'h30 + k));
    // unroutable packet dropped whole, then orphans, then simultaneous orphans
    wr(4'd7, 2'd3);
    b0 = lsz(0) + lsz(1) + lsz(2);
    pkt(2, 7, 'h40, 4);
    repeat (3) @(posedge nocclk);
    #1;
    chk("drop_err", 64'(err_count), 64'd4);
    chk("drop_none_out", 64'(lsz(0) + lsz(1) + lsz(2)), 64'(b0));
    push(0, mk(0, 0, 9, 'h4F));
    repeat (2) @(posedge nocclk);
    #1;
    chk("orphan_err", 64'(err_count), 64'd5);
    fork
      push(0, mk(0, 1, 1, 'h41));
      push(1, mk(0, 0, 1, 'h42));
      push(2, mk(0, 1, 1, 'h43));
    join
    repeat (2) @(posedge nocclk);
    #1;
    chk("multi_err", 64'(err_count), 64'd8);
    // table rewrite during a packet affects only the next packet
    b1 = lsz(1);
    b2 = lsz(2);
    fork
      pkt(0, 5, 'h50, 3);
      begin
        int c = 0;
        while (lsz(2) < b2 + 1 && c < 100) begin
          @(posedge nocclk);
          #1;
          c++;
        end
        wr(4'd5, 2'd1);
      end
    join
    wait_log(2, b2 + 3);
    for (int k = 0; k < 3; k++) chk("inflight", lget(2, b2 + k), mk(k == 0, k == 2, 5, 'h50 + k));
    push(0, mk(1, 1, 5, 'h58));
    wait_log(1, b1 + 1);
    chk("new_route", lget(1, b1), mk(1, 1, 5, 'h58));
    chk("old_port_idle", 64'(lsz(2)), 64'(b2 + 3));
    chk("rewrite_err", 64'(err_count), 64'd8);
    // saturation of the error counter
    fork
      for (int k = 0; k < 90; k++) push(0, mk(0, 0, 1, k));
      for (int k = 0; k < 90; k++) push(1, mk(0, 0, 1, k));
      for (int k = 0; k < 90; k++) push(2, mk(0, 0, 1, k));
    join
    repeat (3) @(posedge nocclk);
    #1;
    chk("sat_err", 64'(err_count), 64'd255);
    push(0, mk(0, 0, 1, 'h99));
    repeat (2) @(posedge nocclk);
    #1;
    chk("sat_hold", 64'(err_count), 64'd255);
    // reset mid-packet drops everything and clears the table
    out_ready[1] = 1'b0;
    push(1, mk(1, 0, 5, 'h60));
    push(1, mk(0, 0, 5, 'h61));
    b0 = lsz(0);
    b1 = lsz(1);
    rst = 1'b1;
    @(negedge nocclk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    @(posedge nocclk);
    #1;
    rst = 1'b0;
    out_ready = 3'b111;
    @(negedge nocclk);
    chk("after_rst_valid", 64'(out_valid), 64'd0);
    chk("after_rst_flit", out_flit[63:0] | out_flit[127:64] | out_flit[191:128], 64'd0);
    chk("after_rst_err", 64'(err_count), 64'd0);
    @(posedge nocclk);
    #1;
    push(2, mk(1, 1, 5, 'h70));
    wait_log(0, b0 + 1);
    chk("after_rst_route", lget(0, b0), mk(1, 1, 5, 'h70));
    repeat (3) @(posedge nocclk);
    #1;
    chk("no_stale", 64'(lsz(1)), 64'(b1));
    chk("single_out", 64'(lsz(0)), 64'(b0 + 1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
